// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up at the end.
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  operation,
  input  logic [31:0] numberA,
  input  logic [31:0] numberB,
  output logic        busy,
  output logic        done,
  output logic        divByZero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state  | meaning
  // IDLE   | waiting for start; MTHI/MTLO handled here in zero cycles
  // RUN    | 32 iterations, one multiplier/quotient bit per cycle
  // FINISH | sign correction, HI/LO write, done pulse
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state;
  logic [4:0]  iter_cnt;
  logic        is_div;
  logic        neg_quo;
  logic        neg_rem;
  logic        zero_div;
  logic [31:0] opnd_b;
  logic [31:0] dividend_raw;
  logic [63:0] acc;

  logic        start_signed;
  logic        start_is_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] acc_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // acc holds {partial product, multiplier} for multiply and
  // {remainder, dividend/quotient bits} for divide; both start as {0, |A|}.
  always_comb begin
    start_signed = ~operation[0];
    start_is_div = operation[1];
    mag_a        = (start_signed && numberA[31]) ? -numberA : numberA;
    mag_b        = (start_signed && numberB[31]) ? -numberB : numberB;
    mul_sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
    div_shift    = {acc[63:32], acc[31]};
    div_diff     = div_shift - {1'b0, opnd_b};
    div_ge       = (div_shift >= {1'b0, opnd_b});
    if (is_div)
      acc_next = div_ge ? {div_diff[31:0], acc[30:0], 1'b1}
                        : {div_shift[31:0], acc[30:0], 1'b0};
    else
      acc_next = {mul_sum, acc[31:1]};
    prod_fix = neg_quo ? -acc : acc;
    quo_fix  = neg_quo ? -acc[31:0] : acc[31:0];
    rem_fix  = neg_rem ? -acc[63:32] : acc[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      divByZero    <= 1'b0;
      hi           <= 32'd0;
      lo           <= 32'd0;
      iter_cnt     <= 5'd0;
      acc          <= 64'd0;
      opnd_b       <= 32'd0;
      dividend_raw <= 32'd0;
      is_div       <= 1'b0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      zero_div     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (operation)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state        <= RUN;
                busy         <= 1'b1;
                divByZero    <= 1'b0;
                iter_cnt     <= 5'd0;
                acc          <= {32'd0, mag_a};
                opnd_b       <= mag_b;
                dividend_raw <= numberA;
                is_div       <= start_is_div;
                neg_quo      <= start_signed & (numberA[31] ^ numberB[31]);
                neg_rem      <= start_signed & numberA[31];
                zero_div     <= start_is_div & (numberB == 32'd0);
              end
              3'd4:    hi <= numberA;
              3'd5:    lo <= numberA;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc      <= acc_next;
          iter_cnt <= iter_cnt + 5'd1;
          if (iter_cnt == 5'd31)
            state <= FINISH;
        end
        FINISH: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          divByZero <= zero_div;
          if (zero_div) begin
            hi <= dividend_raw;
            lo <= 32'hFFFF_FFFF;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] numberA;
  logic [31:0] numberB;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .operation(operation),
    .numberA(numberA), .numberB(numberB), .busy(busy), .done(done),
    .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // architectural HI/LO as the reference model sees them
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  int          busy_cnt, done_cnt, done_k, hold_bad, dbz_run_bad;
  logic [31:0] obs_hi, obs_lo;
  logic        obs_dbz;

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mh, output logic [31:0] ml, output logic md);
    longint      sa, sb, sq, sr;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    md = 1'b0;
    u  = 64'd0;
    case (op)
      3'd0: u = sa * sb;
      3'd1: u = {32'd0, a} * {32'd0, b};
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          u  = {a, 32'hFFFF_FFFF};
          md = 1'b1;
        end else if (op == 3'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          u  = {sr[31:0], sq[31:0]};
        end else begin
          u = {a % b, a / b};
        end
      end
      default: u = {exp_hi, exp_lo};
    endcase
    mh = u[63:32];
    ml = u[31:0];
  endtask

  // Starts an iterative op (or assumes start is already driven) and observes
  // 34 cycles after the accepting edge while scrambling the inputs.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit pre_driven, input bit inject_mtlo);
    if (!pre_driven) begin
      @(negedge clock);
      start = 1'b1; operation = op; numberA = a; numberB = b;
    end
    @(posedge clock);
    busy_cnt = 0; done_cnt = 0; done_k = -1; hold_bad = 0; dbz_run_bad = 0;
    obs_hi = 32'd0; obs_lo = 32'd0; obs_dbz = 1'b0;
    for (int k = 0; k < 34; k++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++; done_k = k; obs_hi = hi; obs_lo = lo; obs_dbz = divByZero;
      end
      if (k < 33 && (hi !== exp_hi || lo !== exp_lo)) hold_bad++;
      if (k < 33 && divByZero !== 1'b0) dbz_run_bad++;
      start = 1'b0; numberA = $urandom; numberB = $urandom;
      operation = 3'($urandom_range(0, 7));
      if (inject_mtlo && k >= 8 && k < 12) begin
        start = 1'b1; operation = 3'd5; numberA = 32'hDEAD_BEEF;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; operation = 3'd4; numberA = 32'hAAAA_5555; numberB = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    operation = 3'd1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (divByZero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", divByZero); end
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_multu_max;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    total++; if (obs_hi !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_max_hi got=%h exp=fffffffe", obs_hi); end
    total++; if (obs_lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_max_lo got=%h exp=00000001", obs_lo); end
    total++; if (busy_cnt !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=33", busy_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL multu_done_pulses got=%0d exp=1", done_cnt); end
    total++; if (done_k !== 33) begin bad++; $display("FAIL multu_done_cycle got=%0d exp=33", done_k); end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL multu_hold got=%0d exp=0", hold_bad); end
    exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h0000_0001;
  endtask

  task automatic test_signed;
    issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    total++; if (obs_hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", obs_hi); end
    total++; if (obs_lo !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_neg_lo got=%h exp=fffffff1", obs_lo); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    total++; if (obs_lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_quo got=%h exp=fffffffd", obs_lo); end
    total++; if (obs_hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_rem got=%h exp=ffffffff", obs_hi); end
    total++; if (obs_dbz !== 1'b0) begin bad++; $display("FAIL div_neg_dbz got=%b exp=0", obs_dbz); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFD;
  endtask

  task automatic test_div_zero;
    issue(3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    total++; if (obs_lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_lo got=%h exp=ffffffff", obs_lo); end
    total++; if (obs_hi !== 32'd7) begin bad++; $display("FAIL divz_hi got=%h exp=7", obs_hi); end
    total++; if (obs_dbz !== 1'b1) begin bad++; $display("FAIL divz_flag got=%b exp=1", obs_dbz); end
    total++; if (done_k !== 33) begin bad++; $display("FAIL divz_latency got=%0d exp=33", done_k); end
    exp_hi = 32'd7; exp_lo = 32'hFFFF_FFFF;
    issue(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
    total++; if (obs_lo !== 32'd3) begin bad++; $display("FAIL divu_quo got=%h exp=3", obs_lo); end
    total++; if (obs_hi !== 32'd1) begin bad++; $display("FAIL divu_rem got=%h exp=1", obs_hi); end
    total++; if (obs_dbz !== 1'b0) begin bad++; $display("FAIL divu_flag got=%b exp=0", obs_dbz); end
    total++; if (dbz_run_bad !== 0) begin bad++; $display("FAIL dbz_clear_on_start got=%0d exp=0", dbz_run_bad); end
    exp_hi = 32'd1; exp_lo = 32'd3;
  endtask

  task automatic test_overflow;
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    total++; if (obs_lo !== 32'h8000_0000) begin bad++; $display("FAIL ovf_quo got=%h exp=80000000", obs_lo); end
    total++; if (obs_hi !== 32'd0) begin bad++; $display("FAIL ovf_rem got=%h exp=0", obs_hi); end
    total++; if (obs_dbz !== 1'b0) begin bad++; $display("FAIL ovf_flag got=%b exp=0", obs_dbz); end
    exp_hi = 32'd0; exp_lo = 32'h8000_0000;
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clock);
    start = 1'b1; operation = 3'd4; numberA = 32'h1234_5678;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    total++; if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL mthi_lo_hold got=%h exp=%h", lo, exp_lo); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mthi_busy_done got=%b%b exp=00", busy, done); end
    exp_hi = 32'h1234_5678;
    issue(3'd1, 32'd3, 32'd4, 1'b0, 1'b1);
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL mtlo_ignored_in_run got=%0d exp=0", hold_bad); end
    total++; if (obs_hi !== 32'd0) begin bad++; $display("FAIL mul34_hi got=%h exp=0", obs_hi); end
    total++; if (obs_lo !== 32'd12) begin bad++; $display("FAIL mul34_lo got=%h exp=c", obs_lo); end
    exp_hi = 32'd0; exp_lo = 32'd12;
  endtask

  task automatic test_reset_mid_run;
    int seen_done;
    @(negedge clock);
    start = 1'b1; operation = 3'd3; numberA = 32'd100; numberB = 32'd7;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL abort_hilo got=%h_%h exp=0_0", hi, lo); end
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
    exp_hi = 32'd0; exp_lo = 32'd0;
    issue(3'd1, 32'd6, 32'd7, 1'b0, 1'b0);
    total++; if (obs_lo !== 32'd42 || obs_hi !== 32'd0) begin bad++; $display("FAIL post_abort_mul got=%h_%h exp=0_2a", obs_hi, obs_lo); end
    total++; if (done_k !== 33) begin bad++; $display("FAIL post_abort_latency got=%0d exp=33", done_k); end
    exp_hi = 32'd0; exp_lo = 32'd42;
  endtask

  task automatic test_back_to_back;
    logic [31:0] mh, ml;
    logic        md;
    issue(3'd1, 32'd1000, 32'd1000, 1'b0, 1'b0);
    model(3'd1, 32'd1000, 32'd1000, mh, ml, md);
    exp_hi = mh; exp_lo = ml;
    start = 1'b1; operation = 3'd2; numberA = 32'hFFFF_FF9C; numberB = 32'd9;
    issue(3'd2, 32'hFFFF_FF9C, 32'd9, 1'b1, 1'b0);
    model(3'd2, 32'hFFFF_FF9C, 32'd9, mh, ml, md);
    total++; if (done_k !== 33) begin bad++; $display("FAIL b2b_latency got=%0d exp=33", done_k); end
    total++; if (obs_hi !== mh || obs_lo !== ml) begin bad++; $display("FAIL b2b_result got=%h_%h exp=%h_%h", obs_hi, obs_lo, mh, ml); end
    exp_hi = mh; exp_lo = ml;
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b, mh, ml;
    logic        md;
    bit          chain;
    chain = 1'b0;
    for (int n = 0; n < 24; n++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      if (op >= 3'd4) begin
        @(negedge clock);
        start = 1'b1; operation = op; numberA = a;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        if (op == 3'd4) exp_hi = a; else exp_lo = a;
        total++; if (hi !== exp_hi || lo !== exp_lo) begin bad++; $display("FAIL rnd_mt%0d got=%h_%h exp=%h_%h", n, hi, lo, exp_hi, exp_lo); end
        chain = 1'b0;
      end else begin
        if (chain) begin
          start = 1'b1; operation = op; numberA = a; numberB = b;
        end
        issue(op, a, b, chain, 1'b0);
        model(op, a, b, mh, ml, md);
        total++;
        if (obs_hi !== mh || obs_lo !== ml || obs_dbz !== md || done_k !== 33 || hold_bad !== 0) begin
          bad++;
          $display("FAIL rnd_op%0d op=%0d a=%h b=%h got=%h_%h dbz=%b k=%0d hold=%0d exp=%h_%h dbz=%b k=33 hold=0",
                   n, op, a, b, obs_hi, obs_lo, obs_dbz, done_k, hold_bad, mh, ml, md);
        end
        exp_hi = mh; exp_lo = ml;
        chain = bit'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; operation = 3'd0; numberA = 32'd0; numberB = 32'd0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_overflow();
    test_mthi_mtlo();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
